// File: rtl/svm_seq_ctrl_if.sv
// Handshake, ROM and result bus of the SVM sequencing controller.
// The master modport is the controller side; the slave modport is the surrounding datapath.
interface svm_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 6,
  parameter int SIDX_W = 3
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     rom_en;
  logic [ADDR_W-1:0]        rom_addr_w;
  logic [ADDR_W-1:0]        rom_addr_x;
  logic signed [DATA_W-1:0] w_data;
  logic signed [DATA_W-1:0] x_data;
  logic signed [ACC_W-1:0]  bias;
  logic signed [ACC_W-1:0]  score;
  logic                     class_out;
  logic                     class_valid;
  logic [SIDX_W-1:0]        sample_idx;

  modport master (
    input  start, w_data, x_data, bias,
    output busy, done, rom_en, rom_addr_w, rom_addr_x,
           score, class_out, class_valid, sample_idx
  );

  modport slave (
    output start, w_data, x_data, bias,
    input  busy, done, rom_en, rom_addr_w, rom_addr_x,
           score, class_out, class_valid, sample_idx
  );
endinterface

// File: rtl/svm_seq_ctrl.sv
// Linear SVM sequencing controller: per sample, fetch features, MAC, add bias, emit class.
// Define SVM_SAT_EN to saturate the accumulate and bias add instead of wrapping.
module svm_seq_ctrl #(
  parameter int N_FEAT    = 8,
  parameter int N_SAMPLES = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int ADDR_W    = 6
) (
  input logic            clk,
  input logic            rst,
  svm_seq_ctrl_if.master bus
);
  localparam int SIDX_W = $clog2(N_SAMPLES) + 1;
  localparam int FIDX_W = $clog2(N_FEAT) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DECIDE = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [FIDX_W-1:0] FEAT_LAST = FIDX_W'(N_FEAT - 1);
  localparam logic [SIDX_W-1:0] SAMP_LAST = SIDX_W'(N_SAMPLES - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit detects signed overflow of the ACC_W-bit sum.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef SVM_SAT_EN
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      return sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      return sum[ACC_W-1:0];
    end
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  logic [2:0]                state_r, state_nxt_s;
  logic [SIDX_W-1:0]         samp_cnt_r;
  logic [FIDX_W-1:0]         feat_cnt_r;
  logic                      dv_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic                      busy_r, done_r, rom_en_r, cv_r, class_r;
  logic [ADDR_W-1:0]         addr_w_r, addr_x_r;
  logic signed [ACC_W-1:0]   score_r, score_nxt_s;
  logic [SIDX_W-1:0]         sidx_r;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;

  assign prod_s      = bus.w_data * bus.x_data;
  assign prod_ext_s  = ACC_W'(prod_s);
  assign score_nxt_s = acc_add(acc_r, bus.bias);

  // Next-state decode of the sequencing FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   state_nxt_s = bus.start ? S_CLEAR : S_IDLE;
      S_CLEAR:  state_nxt_s = S_FETCH;
      S_FETCH:  state_nxt_s = (feat_cnt_r == FEAT_LAST) ? S_DRAIN : S_FETCH;
      S_DRAIN:  state_nxt_s = S_DECIDE;
      S_DECIDE: state_nxt_s = S_NEXT;
      S_NEXT:   state_nxt_s = (samp_cnt_r == SAMP_LAST) ? S_DONE : S_CLEAR;
      S_DONE:   state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // State, counters, ROM strobe/addresses and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      samp_cnt_r <= {SIDX_W{1'b0}};
      feat_cnt_r <= {FIDX_W{1'b0}};
      dv_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cv_r       <= 1'b0;
      rom_en_r   <= 1'b0;
      addr_w_r   <= {ADDR_W{1'b0}};
      addr_x_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
      done_r  <= (state_nxt_s == S_DONE);
      cv_r    <= (state_r == S_DECIDE);
      dv_r    <= rom_en_r;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            samp_cnt_r <= {SIDX_W{1'b0}};
          end
        end
        S_CLEAR: begin
          feat_cnt_r <= {FIDX_W{1'b0}};
          rom_en_r   <= 1'b1;
          addr_w_r   <= {ADDR_W{1'b0}};
          addr_x_r   <= ADDR_W'(int'(samp_cnt_r) * N_FEAT);
        end
        S_FETCH: begin
          feat_cnt_r <= feat_cnt_r + {{(FIDX_W-1){1'b0}}, 1'b1};
          // Addresses return to zero together with the strobe.
          if (feat_cnt_r == FEAT_LAST) begin
            rom_en_r <= 1'b0;
            addr_w_r <= {ADDR_W{1'b0}};
            addr_x_r <= {ADDR_W{1'b0}};
          end else begin
            addr_w_r <= ADDR_W'(feat_cnt_r) + {{(ADDR_W-1){1'b0}}, 1'b1};
            addr_x_r <= addr_x_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        S_NEXT: begin
          if (samp_cnt_r != SAMP_LAST) begin
            samp_cnt_r <= samp_cnt_r + {{(SIDX_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Accumulator: cleared per sample, adds each product the cycle after its fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (state_r == S_CLEAR) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (dv_r) begin
      acc_r <= acc_add(acc_r, prod_ext_s);
    end
  end

  // Result registers, held until the next decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_r <= {ACC_W{1'b0}};
      class_r <= 1'b0;
      sidx_r  <= {SIDX_W{1'b0}};
    end else if (state_r == S_DECIDE) begin
      score_r <= score_nxt_s;
      class_r <= ~score_nxt_s[ACC_W-1];
      sidx_r  <= samp_cnt_r;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.rom_en      = rom_en_r;
  assign bus.rom_addr_w  = addr_w_r;
  assign bus.rom_addr_x  = addr_x_r;
  assign bus.score       = score_r;
  assign bus.class_out   = class_r;
  assign bus.class_valid = cv_r;
  assign bus.sample_idx  = sidx_r;
endmodule
